// File: rtl/marble_pkg.sv
// Shared types and marble code constants for the marble dispenser.
// The moisture classifier reuses the same marble code constants.
package marble_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      OPEN   = 3'd1,
      SETTLE = 3'd2,
      DONE   = 3'd3,
      FAULT  = 3'd4
   } state_e;

   localparam logic [1:0] MARBLE_NONE  = 2'b00;
   localparam logic [1:0] MARBLE_ONE   = 2'b01;
   localparam logic [1:0] MARBLE_TWO   = 2'b10;
   localparam logic [1:0] MARBLE_THREE = 2'b11;

endpackage

// File: rtl/marble_dispenser_if.sv
// Classifier/actuator-side signal bundle for the marble dispenser.
// Optional macro MARBLE_TOTAL_EN adds the lifetime total_marbles output.
interface marble_dispenser_if;

   logic [1:0]  marble;
   logic        dispense_req;
   logic        drop_sense;
   logic        fault_clr;
   logic        gate_open;
   logic        busy;
   logic        done;
   logic        fault;
   logic [1:0]  dispensed;
`ifdef MARBLE_TOTAL_EN
   logic [15:0] total_marbles;
`endif

   modport master (
      output marble, dispense_req, drop_sense, fault_clr,
`ifdef MARBLE_TOTAL_EN
      input  total_marbles,
`endif
      input  gate_open, busy, done, fault, dispensed
   );

   modport slave (
      input  marble, dispense_req, drop_sense, fault_clr,
`ifdef MARBLE_TOTAL_EN
      output total_marbles,
`endif
      output gate_open, busy, done, fault, dispensed
   );

endinterface

// File: rtl/marble_edge_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge pulse.
// The pulse appears STAGES+1 cycles after the asynchronous input rises.
module marble_edge_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic pulse
);

   localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] sync_q, sync_d;
   logic         prev_q, prev_d;
   logic         pulse_q, pulse_d;

   always_comb begin
      sync_d  = {sync_q[N-2:0], async_in};
      prev_d  = sync_q[N-1];
      pulse_d = sync_q[N-1] & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/marble_dispenser.sv
// Dispenses 0-3 marbles one at a time, confirming each drop and settling between.
// Optional macro MARBLE_TOTAL_EN adds a saturating lifetime drop counter.
//
//   state  | meaning
//   IDLE   | waiting for dispense_req, target latched on accept
//   OPEN   | gate open, waiting for a drop or timeout
//   SETTLE | gate closed, settle timer running, drops ignored
//   DONE   | one-cycle completion pulse
//   FAULT  | gate open timeout, held until fault_clr
module marble_dispenser
   import marble_pkg::*;
#(
   parameter int unsigned GATE_OPEN_MAX = 100000000,
   parameter int unsigned SETTLE_CYCLES = 25000000,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   marble_dispenser_if.slave bus
);

   localparam int unsigned TMR_MAX = (GATE_OPEN_MAX > SETTLE_CYCLES) ? GATE_OPEN_MAX : SETTLE_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] OPEN_LAST   = TMR_W'(GATE_OPEN_MAX - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [1:0]         target_q, target_d;
   logic [1:0]         dispensed_q, dispensed_d;
   logic               drop_evt;
   logic               count_evt;

   marble_edge_sync #(.STAGES(SYNC_STAGES)) u_drop_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (bus.drop_sense),
      .pulse    (drop_evt)
   );

   assign count_evt = (state_q == OPEN) && drop_evt;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      target_d    = target_q;
      dispensed_d = dispensed_q;
      case (state_q)
         IDLE: begin
            if (bus.dispense_req) begin
               target_d    = bus.marble;
               dispensed_d = '0;
               timer_d     = '0;
               state_d     = (bus.marble == MARBLE_NONE) ? DONE : OPEN;
            end
         end
         OPEN: begin
            // a drop on the final open cycle still counts rather than faulting
            if (drop_evt) begin
               dispensed_d = dispensed_q + 2'd1;
               timer_d     = '0;
               state_d     = SETTLE;
            end else if (timer_q == OPEN_LAST) begin
               timer_d = '0;
               state_d = FAULT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         SETTLE: begin
            if (timer_q == SETTLE_LAST) begin
               timer_d = '0;
               state_d = (dispensed_q == target_q) ? DONE : OPEN;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         FAULT:   if (bus.fault_clr) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         target_q    <= '0;
         dispensed_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         target_q    <= target_d;
         dispensed_q <= dispensed_d;
      end
   end

   // outputs decode directly from the async-reset state register
   assign bus.gate_open = (state_q == OPEN);
   assign bus.busy      = (state_q != IDLE) && (state_q != FAULT);
   assign bus.done      = (state_q == DONE);
   assign bus.fault     = (state_q == FAULT);
   assign bus.dispensed = dispensed_q;

`ifdef MARBLE_TOTAL_EN
   logic [15:0] total_q, total_d;

   always_comb begin
      total_d = total_q;
      if (count_evt && (total_q != 16'hFFFF)) total_d = total_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) total_q <= '0;
      else        total_q <= total_d;
   end

   assign bus.total_marbles = total_q;
`endif

endmodule

// File: tb/tb_marble_dispenser.sv
// Directed bench for marble_dispenser with GATE_OPEN_MAX=50, SETTLE_CYCLES=10.
// Define MARBLE_TOTAL_EN to also check the lifetime total counter.
module tb_marble_dispenser;
   import marble_pkg::*;

   localparam int unsigned GOM = 50;
   localparam int unsigned SC  = 10;
   localparam int unsigned SS  = 2;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   marble_dispenser_if bus ();

   marble_dispenser #(
      .GATE_OPEN_MAX (GOM),
      .SETTLE_CYCLES (SC),
      .SYNC_STAGES   (SS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_drop();
      bus.drop_sense = 1'b1;
      tick();
      tick();
      bus.drop_sense = 1'b0;
   endtask

`ifdef MARBLE_TOTAL_EN
   task automatic run_seq(input logic [1:0] code);
      bus.marble       = code;
      bus.dispense_req = 1'b1;
      tick();
      bus.dispense_req = 1'b0;
      for (int i = 0; i < int'(code); i++) begin
         repeat (2) tick();
         pulse_drop();
         repeat (2) tick();
         repeat (SC) tick();
      end
      tick();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n            = 1'b1;
      bus.marble       = MARBLE_THREE;
      bus.dispense_req = 1'b1;
      bus.drop_sense   = 1'b0;
      bus.fault_clr    = 1'b0;
      #2 rst_n = 1'b0;

      // reset held with a pending 3-marble request
      repeat (3) tick();
      chk("rst_outputs", {bus.gate_open, bus.busy, bus.done, bus.fault, bus.dispensed}, 0);
      rst_n = 1'b1;
      #1 chk("rst_release_idle", bus.busy, 0);
      tick();
      chk("a_open_after_rst", bus.gate_open, 1);
      chk("a_busy", bus.busy, 1);
      bus.dispense_req = 1'b0;
      bus.marble       = MARBLE_ONE;

      repeat (5) tick();
      pulse_drop();
      tick();
      chk("a_gate_hold", bus.gate_open, 1);
      tick();
      chk("a_gate_close", bus.gate_open, 0);
      chk("a_disp1", bus.dispensed, 1);
      pulse_drop();
      repeat (7) tick();
      chk("a_settle_closed", bus.gate_open, 0);
      tick();
      chk("a_reopen", bus.gate_open, 1);
      chk("a_extra_ignored", bus.dispensed, 1);
      pulse_drop();
      repeat (2) tick();
      chk("a_disp2", bus.dispensed, 2);
      repeat (10) tick();
      chk("a_reopen2", bus.gate_open, 1);
      pulse_drop();
      repeat (2) tick();
      chk("a_disp3", bus.dispensed, 3);
      chk("a_closed3", bus.gate_open, 0);
      repeat (9) tick();
      chk("a_no_early_done", bus.done, 0);
      tick();
      chk("a_done", bus.done, 1);
      chk("a_done_busy", bus.busy, 1);
      chk("a_done_disp", bus.dispensed, 3);
      tick();
      chk("a_done_one_cycle", bus.done, 0);
      chk("a_idle_busy", bus.busy, 0);

      // single marble
      bus.marble       = MARBLE_ONE;
      bus.dispense_req = 1'b1;
      tick();
      bus.dispense_req = 1'b0;
      chk("b_open", bus.gate_open, 1);
      chk("b_disp_cleared", bus.dispensed, 0);
      repeat (5) tick();
      pulse_drop();
      tick();
      chk("b_gate_hold", bus.gate_open, 1);
      tick();
      chk("b_gate_close", bus.gate_open, 0);
      chk("b_disp1", bus.dispensed, 1);
      repeat (9) tick();
      chk("b_no_early_done", bus.done, 0);
      tick();
      chk("b_done", bus.done, 1);
      tick();
      chk("b_done_one_cycle", bus.done, 0);

      // two marbles, no drops: timeout
      bus.marble       = MARBLE_TWO;
      bus.dispense_req = 1'b1;
      tick();
      bus.dispense_req = 1'b0;
      repeat (49) tick();
      chk("c_open_last", bus.gate_open, 1);
      chk("c_no_early_fault", bus.fault, 0);
      tick();
      chk("c_fault", bus.fault, 1);
      chk("c_fault_gate", bus.gate_open, 0);
      chk("c_fault_busy", bus.busy, 0);
      bus.dispense_req = 1'b1;
      bus.marble       = MARBLE_THREE;
      repeat (2) tick();
      chk("c_req_ignored", bus.fault, 1);
      chk("c_req_ignored_gate", bus.gate_open, 0);
      bus.dispense_req = 1'b0;
      bus.fault_clr    = 1'b1;
      tick();
      bus.fault_clr = 1'b0;
      chk("c_clr_fault", bus.fault, 0);
      chk("c_clr_busy", bus.busy, 0);
      chk("c_clr_disp", bus.dispensed, 0);
      tick();
      chk("c_stay_idle", bus.busy, 0);

      // zero-marble request
      bus.marble       = MARBLE_NONE;
      bus.dispense_req = 1'b1;
      tick();
      bus.dispense_req = 1'b0;
      chk("d_done", bus.done, 1);
      chk("d_gate", bus.gate_open, 0);
      tick();
      chk("d_done_one_cycle", bus.done, 0);
      chk("d_gate2", bus.gate_open, 0);

      // reset during the second open window
      bus.marble       = MARBLE_TWO;
      bus.dispense_req = 1'b1;
      tick();
      bus.dispense_req = 1'b0;
      pulse_drop();
      repeat (2) tick();
      chk("e_disp1", bus.dispensed, 1);
      repeat (10) tick();
      chk("e_second_open", bus.gate_open, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("e_async_gate", bus.gate_open, 0);
      chk("e_disp_rst", bus.dispensed, 0);
      chk("e_busy_rst", bus.busy, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("e_idle_busy", bus.busy, 0);
      chk("e_idle_gate", bus.gate_open, 0);

`ifdef MARBLE_TOTAL_EN
      chk("t_total_rst", bus.total_marbles, 0);
      run_seq(MARBLE_ONE);
      run_seq(MARBLE_TWO);
      run_seq(MARBLE_THREE);
      chk("t_total_six", bus.total_marbles, 6);
      chk("t_last_disp", bus.dispensed, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
